// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU and debug/loader share one combinational-read memory.
// The CPU normally wins, and the debug port is forced through after STARVE_LIMIT consecutive CPU wins.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,  // legal range 1..15
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [3:0]        starve_cnt
);

  // Handshake: a requester raises req with stable fields and holds them until it sees
  // gnt; the transfer happens in the cycle where req & gnt are both high. A load
  // returns rvalid/rdata for exactly the following cycle. Stores return nothing.

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q;
  logic              cpu_rv_q;
  logic              dbg_rv_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] dbg_rd_q;
  logic              cpu_load;
  logic              dbg_load;

  assign dbg_gnt   = ~reset & dbg_req & (~cpu_req | (starve_q == LIMIT));
  assign cpu_gnt   = ~reset & cpu_req & ~dbg_gnt;
  assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;
  assign cpu_load  = cpu_gnt & ~cpu_we;
  assign dbg_load  = dbg_gnt & ~dbg_we;

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (cpu_gnt) begin
      mem_read       = ~cpu_we;
      mem_write      = cpu_we;
      mem_address    = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_read       = ~dbg_we;
      mem_write      = dbg_we;
      mem_address    = dbg_addr;
      mem_write_data = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      cpu_rv_q <= 1'b0;
      dbg_rv_q <= 1'b0;
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      if (dbg_gnt || !dbg_req) begin
        starve_q <= '0;
      end else if (cpu_gnt && starve_q < LIMIT) begin
        starve_q <= starve_q + 4'd1;
      end
      cpu_rv_q <= cpu_load;
      dbg_rv_q <= dbg_load;
      if (cpu_load) cpu_rd_q <= mem_read_data;
      if (dbg_load) dbg_rd_q <= mem_read_data;
    end
  end

  // Reset masks the response registers immediately so a load granted just before
  // reset is dropped rather than delivered during or after reset.
  assign cpu_rvalid = cpu_rv_q & ~reset;
  assign dbg_rvalid = dbg_rv_q & ~reset;
  assign cpu_rdata  = reset ? '0 : cpu_rd_q;
  assign dbg_rdata  = reset ? '0 : dbg_rd_q;
  assign starve_cnt = reset ? 4'd0 : starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a queue-free behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int LIMIT = 3;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         cpu_req, cpu_we, dbg_req, dbg_we;
  logic [W-1:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic         cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [W-1:0] cpu_rdata, dbg_rdata;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]   starve_cnt;

  logic [W-1:0] mem_arr [64];
  assign mem_read_data = mem_arr[mem_address[7:2]];

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .starve_cnt(starve_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // The model counts how many times in a row dbg has lost while waiting,
  // and remembers the word each port is owed on the next cycle.
  int           m_losses = 0;
  logic         m_cpu_owed = 1'b0, m_dbg_owed = 1'b0;
  logic [W-1:0] m_cpu_word = '0, m_dbg_word = '0;

  always @(negedge clk) begin
    logic         e_cg, e_dg, e_rd, e_wr;
    logic [W-1:0] e_addr, e_wd;
    if (reset) begin
      e_cg = 0; e_dg = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, '0);
      chk("rst_dbg_rdata", dbg_rdata, '0);
      chk("rst_starve_cnt", starve_cnt, 4'd0);
    end else begin
      e_dg = dbg_req && (!cpu_req || m_losses == LIMIT);
      e_cg = cpu_req && !e_dg;
      e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (e_cg) begin e_rd = !cpu_we; e_wr = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
      if (e_dg) begin e_rd = !dbg_we; e_wr = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end
      chk("cpu_rvalid", cpu_rvalid, m_cpu_owed);
      chk("dbg_rvalid", dbg_rvalid, m_dbg_owed);
      chk("cpu_rdata", cpu_rdata, m_cpu_word);
      chk("dbg_rdata", dbg_rdata, m_dbg_word);
      chk("starve_cnt", starve_cnt, 4'(m_losses));
    end
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("dbg_gnt", dbg_gnt, e_dg);
    chk("cpu_stall", cpu_stall, !reset && cpu_req && !e_cg);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_address", mem_address, e_addr);
    chk("mem_write_data", mem_write_data, e_wd);
    // advance model to what the next cycle must show
    if (reset) begin
      m_losses = 0; m_cpu_owed = 0; m_dbg_owed = 0; m_cpu_word = '0; m_dbg_word = '0;
    end else begin
      if (!dbg_req || e_dg) m_losses = 0;
      else if (m_losses < LIMIT) m_losses = m_losses + 1;
      m_cpu_owed = e_cg && !cpu_we;
      m_dbg_owed = e_dg && !dbg_we;
      if (m_cpu_owed) m_cpu_word = mem_arr[cpu_addr[7:2]];
      if (m_dbg_owed) m_dbg_word = mem_arr[dbg_addr[7:2]];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic idle();
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [4:0] exp_cpu_seq;
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'hC0FFEE00 | 32'(i);
    mem_arr[4] = 32'hDEADBEEF;
    reset = 1'b1;
    idle();
    #2;
    chk("lit_rst_gnt", {cpu_gnt, dbg_gnt, mem_read, mem_write}, 4'b0000);
    tick(); tick();
    reset = 1'b0;

    // CPU-only load from 0x10 in the first cycle out of reset
    set_cpu(1, 0, 32'h10, '0);
    #2;
    chk("lit_load_gnt", {cpu_gnt, mem_read, cpu_stall}, 3'b110);
    chk("lit_load_addr", mem_address, 32'h10);
    tick(); idle(); #2;
    chk("lit_load_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b10);
    chk("lit_load_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();

    // Both requesting for 5 cycles: cpu,cpu,cpu,dbg,cpu
    exp_cpu_seq = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      set_cpu(1, 0, 32'h8, '0);
      set_dbg(1, 0, 32'h30, '0);
      #2;
      chk("lit_starve_cpu_gnt", cpu_gnt, exp_cpu_seq[i]);
      chk("lit_starve_stall", cpu_stall, !exp_cpu_seq[i]);
      tick();
    end
    idle(); tick();

    // Debug store alone: no response next cycle
    set_dbg(1, 1, 32'h20, 32'h55);
    #2;
    chk("lit_dst_ctl", {dbg_gnt, mem_write, mem_read}, 3'b110);
    chk("lit_dst_wdata", mem_write_data, 32'h55);
    tick(); idle(); #2;
    chk("lit_dst_no_rvalid", dbg_rvalid, 1'b0);
    tick();

    // Back-to-back CPU loads 0x0 then 0x4
    set_cpu(1, 0, 32'h0, '0); #2;
    chk("lit_b2b_gnt0", cpu_gnt, 1'b1);
    tick(); set_cpu(1, 0, 32'h4, '0); #2;
    chk("lit_b2b_gnt1", cpu_gnt, 1'b1);
    chk("lit_b2b_rd0", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hC0FFEE00});
    tick(); idle(); #2;
    chk("lit_b2b_rd1", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hC0FFEE01});
    tick();

    // Reset right after a load grant loses the response
    set_cpu(1, 0, 32'h10, '0);
    tick(); idle(); reset = 1'b1; #2;
    chk("lit_rstmid_rvalid", cpu_rvalid, 1'b0);
    chk("lit_rstmid_outs", {cpu_gnt, dbg_gnt, mem_read, mem_write, cpu_rdata}, '0);
    chk("lit_rstmid_cnt", starve_cnt, 4'd0);
    tick(); reset = 1'b0; #2;
    chk("lit_rstmid_lost", cpu_rvalid, 1'b0);
    tick();

    // Counter clear: both x2, cpu alone x1, then dbg must wait three more cpu wins
    for (int i = 0; i < 7; i++) begin
      set_cpu(1, 1, 32'h40, 32'h11);
      set_dbg(i != 2, 1, 32'h44, 32'h22);
      #2;
      if (i == 6) chk("lit_clear_dbg_wins", dbg_gnt, 1'b1);
      else        chk("lit_clear_cpu_wins", cpu_gnt, 1'b1);
      tick();
    end
    idle(); tick();

    // Mixed traffic checked by the model only
    for (int i = 0; i < 40; i++) begin
      set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)) << 2, $urandom);
      set_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)) << 2, $urandom);
      tick();
    end
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
